// File: rtl/aes_pkg.sv
// -----------------------------------------------------------------------------
// aes_pkg
// Shared definitions for the iterative AES-256 round scheduler.
//   - aes_state_e : scheduler FSM state encoding (IDLE=0, INIT, ROUND, FINAL,
//                   DONE)
//   - AES_NR_256, AES_BLOCK, AES_KEY_256 : default round count and widths
//   - rk_w()      : width of a round-key index able to hold 0..nr
// -----------------------------------------------------------------------------
package aes_pkg;

  localparam int AES_NR_256  = 14;
  localparam int AES_BLOCK   = 128;
  localparam int AES_KEY_256 = 256;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INIT  = 3'd1,
    ROUND = 3'd2,
    FINAL = 3'd3,
    DONE  = 3'd4
  } aes_state_e;

  // Index width for round keys 0..nr. A single-round configuration still
  // needs one bit to tell key 0 from key 1.
  function automatic int rk_w(input int nr);
    return (nr < 1) ? 1 : $clog2(nr + 1);
  endfunction

endpackage

// File: rtl/aes_round_cnt.sv
// -----------------------------------------------------------------------------
// aes_round_cnt
// Loadable up-counter that tracks the current AES round and flags the last
// MixColumns round (count == NR-1) and the zero count.
//
// Ports:
//   clk          in   clock, rising edge
//   i_rst        in   synchronous active-high reset, clears the count
//   i_load       in   load i_load_val (takes priority over i_inc)
//   i_load_val   in   W  value to load
//   i_inc        in   increment by one
//   o_cnt        out  W  current count
//   o_last_mid   out  count equals NR-1 (last round that uses MixColumns)
//   o_zero       out  count equals zero
// -----------------------------------------------------------------------------
module aes_round_cnt
  import aes_pkg::*;
#(
  parameter int NR = AES_NR_256,
  parameter int W  = rk_w(NR)
) (
  input  logic         clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt,
  output logic         o_last_mid,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_inc) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign o_cnt      = r_cnt;
  assign o_last_mid = (r_cnt == W'(NR - 1));
  assign o_zero     = (r_cnt == '0);

endmodule

// File: rtl/aes_round_sched.sv
// -----------------------------------------------------------------------------
// aes_round_sched
// Iterative AES-256 round scheduler. Accepts a plaintext block (and, in IDLE,
// a cipher key) through a valid/ready handshake, holds the 128-bit cipher
// state and steps an external single-round datapath / key-expansion unit
// through rounds 0..NUMS_OF_ROUND. The ciphertext is then offered with
// valid/ready backpressure.
//
// Build option: define AES_SCHED_ABORT_EN to add the 'abort' input, which
// returns a busy scheduler to IDLE (the latched key is kept).
//
// Ports:
//   clk             in   clock, rising edge
//   reset           in   synchronous active-high reset
//   abort           in   (AES_SCHED_ABORT_EN only) abandon current block
//   data_valid_in   in   plaintext valid
//   data_ready_out  out  plaintext accepted when high together with valid
//   plain_text      in   DATA_LEN plaintext block
//   key_valid_in    in   cipher_key valid, sampled only in IDLE
//   cipher_key      in   KEY_LEN cipher key
//   data_valid_out  out  ciphertext valid
//   data_ready_in   in   downstream ready
//   cipher_text     out  DATA_LEN ciphertext (the state register)
//   key_o           out  KEY_LEN latched key for key expansion
//   rk_idx_o        out  requested round-key index
//   rk_i            in   DATA_LEN round key for rk_idx_o (combinational)
//   rnd_state_o     out  DATA_LEN state presented to the round datapath
//   rnd_mix_en_o    out  MixColumns enable, low only in the final round
//   rnd_state_i     in   DATA_LEN round datapath result
// -----------------------------------------------------------------------------
module aes_round_sched
  import aes_pkg::*;
#(
  parameter int KEY_LEN       = AES_KEY_256,
  parameter int DATA_LEN      = AES_BLOCK,
  parameter int NUMS_OF_ROUND = AES_NR_256
) (
  input  logic                             clk,
  input  logic                             reset,
`ifdef AES_SCHED_ABORT_EN
  input  logic                             abort,
`endif
  input  logic                             data_valid_in,
  output logic                             data_ready_out,
  input  logic [DATA_LEN-1:0]              plain_text,
  input  logic                             key_valid_in,
  input  logic [KEY_LEN-1:0]               cipher_key,
  output logic                             data_valid_out,
  input  logic                             data_ready_in,
  output logic [DATA_LEN-1:0]              cipher_text,
  output logic [KEY_LEN-1:0]               key_o,
  output logic [rk_w(NUMS_OF_ROUND)-1:0]   rk_idx_o,
  input  logic [DATA_LEN-1:0]              rk_i,
  output logic [DATA_LEN-1:0]              rnd_state_o,
  output logic                             rnd_mix_en_o,
  input  logic [DATA_LEN-1:0]              rnd_state_i
);

  localparam int RK_W = rk_w(NUMS_OF_ROUND);

  aes_state_e          r_state;
  aes_state_e          w_state_nxt;

  logic [KEY_LEN-1:0]  r_key;
  logic                r_key_loaded;
  logic [DATA_LEN-1:0] r_blk;

  logic                w_key_ld;
  logic                w_blk_ld;
  logic [DATA_LEN-1:0] w_blk_nxt;

  logic                w_cnt_load;
  logic [RK_W-1:0]     w_cnt_load_val;
  logic                w_cnt_inc;
  logic [RK_W-1:0]     w_cnt;
  logic                w_cnt_last;
  logic                w_unused_cnt_zero;

  logic                w_ready;
  logic                w_valid;
  logic [RK_W-1:0]     w_rk_idx;
  logic                w_mix_en;

  aes_round_cnt #(
    .NR (NUMS_OF_ROUND),
    .W  (RK_W)
  ) u_round_cnt (
    .clk        (clk),
    .i_rst      (reset),
    .i_load     (w_cnt_load),
    .i_load_val (w_cnt_load_val),
    .i_inc      (w_cnt_inc),
    .o_cnt      (w_cnt),
    .o_last_mid (w_cnt_last),
    .o_zero     (w_unused_cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_key_ld       = 1'b0;
    w_blk_ld       = 1'b0;
    w_blk_nxt      = r_blk;
    w_cnt_load     = 1'b0;
    w_cnt_load_val = '0;
    w_cnt_inc      = 1'b0;
    w_ready        = 1'b0;
    w_valid        = 1'b0;
    w_rk_idx       = w_cnt;
    w_mix_en       = 1'b1;

    case (r_state)
      IDLE: begin
        // A key offered alongside the first block makes the block acceptable
        // and is the key that block uses.
        w_ready  = !reset && (r_key_loaded || key_valid_in);
        w_key_ld = key_valid_in;
        if (w_ready && data_valid_in) begin
          w_blk_ld       = 1'b1;
          w_blk_nxt      = plain_text;
          w_cnt_load     = 1'b1;
          w_cnt_load_val = '0;
          w_state_nxt    = INIT;
        end
      end

      INIT: begin
        // Initial AddRoundKey with round key 0; the counter is still 0 here.
        w_blk_ld       = 1'b1;
        w_blk_nxt      = r_blk ^ rk_i;
        w_cnt_load     = 1'b1;
        w_cnt_load_val = RK_W'(1);
        w_state_nxt    = (NUMS_OF_ROUND == 1) ? FINAL : ROUND;
      end

      ROUND: begin
        w_blk_ld  = 1'b1;
        w_blk_nxt = rnd_state_i;
        w_cnt_inc = 1'b1;
        if (w_cnt_last) begin
          w_state_nxt = FINAL;
        end
      end

      FINAL: begin
        w_rk_idx    = RK_W'(NUMS_OF_ROUND);
        w_mix_en    = 1'b0;
        w_blk_ld    = 1'b1;
        w_blk_nxt   = rnd_state_i;
        w_state_nxt = DONE;
      end

      DONE: begin
        w_valid = 1'b1;
        if (data_ready_in) begin
          w_state_nxt = IDLE;
        end
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase

`ifdef AES_SCHED_ABORT_EN
    // Abort wins over everything outside IDLE, including the DONE handshake.
    if (abort && (r_state != IDLE)) begin
      w_state_nxt = IDLE;
      w_blk_ld    = 1'b0;
      w_cnt_load  = 1'b0;
      w_cnt_inc   = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_key        <= '0;
      r_key_loaded <= 1'b0;
      r_blk        <= '0;
    end else begin
      if (w_key_ld) begin
        r_key        <= cipher_key;
        r_key_loaded <= 1'b1;
      end
      if (w_blk_ld) begin
        r_blk <= w_blk_nxt;
      end
    end
  end

  assign data_ready_out = w_ready;
  assign data_valid_out = w_valid;
  assign cipher_text    = r_blk;
  assign rnd_state_o    = r_blk;
  assign key_o          = r_key;
  assign rk_idx_o       = w_rk_idx;
  assign rnd_mix_en_o   = w_mix_en;

endmodule

// File: tb/tb_aes_round_sched.sv
module tb_aes_round_sched;

  localparam logic [255:0] K_FIPS  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] PT_FIPS = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_FIPS = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] CT_ZERO = 128'hdc95c078a2408989ad48a21492842087;
  localparam logic [127:0] PT_ALT  = 128'h0123456789abcdeffedcba9876543210;

  logic         clk;
  logic         reset;
  logic         data_valid_in;
  logic         data_ready_out;
  logic [127:0] plain_text;
  logic         key_valid_in;
  logic [255:0] cipher_key;
  logic         data_valid_out;
  logic         data_ready_in;
  logic [127:0] cipher_text;
  logic [255:0] key_o;
  logic [3:0]   rk_idx_o;
  logic [127:0] rk_i;
  logic [127:0] rnd_state_o;
  logic         rnd_mix_en_o;
  logic [127:0] rnd_state_i;
`ifdef AES_SCHED_ABORT_EN
  logic         abort;
`endif

  int total;
  int bad;

  aes_round_sched dut (
    .clk            (clk),
    .reset          (reset),
`ifdef AES_SCHED_ABORT_EN
    .abort          (abort),
`endif
    .data_valid_in  (data_valid_in),
    .data_ready_out (data_ready_out),
    .plain_text     (plain_text),
    .key_valid_in   (key_valid_in),
    .cipher_key     (cipher_key),
    .data_valid_out (data_valid_out),
    .data_ready_in  (data_ready_in),
    .cipher_text    (cipher_text),
    .key_o          (key_o),
    .rk_idx_o       (rk_idx_o),
    .rk_i           (rk_i),
    .rnd_state_o    (rnd_state_o),
    .rnd_mix_en_o   (rnd_mix_en_o),
    .rnd_state_i    (rnd_state_i)
  );

  always #5 clk = ~clk;

  // ---------------- reference AES model (key expansion + one round) -------
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  // S-box from the GF(2^8) inverse (a^254) followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] inv;
    logic [7:0] base;
    inv  = 8'h01;
    base = a;
    for (int i = 0; i < 8; i++) begin
      if (i != 0) inv = gmul(inv, base);
      base = gmul(base, base);
    end
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [127:0] round_key(input logic [255:0] k, input int r_in);
    logic [31:0] w [0:59];
    logic [31:0] t;
    logic [7:0]  rc;
    int          r;
    r  = (r_in > 14) ? 14 : r_in;
    rc = 8'h01;
    for (int i = 0; i < 8; i++) w[i] = k[255 - 32 * i -: 32];
    for (int i = 8; i < 60; i++) begin
      t = w[i - 1];
      if (i % 8 == 0) begin
        t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
        rc = xtime(rc);
      end else if (i % 8 == 4) begin
        t = sub_word(t);
      end
      w[i] = w[i - 8] ^ t;
    end
    return {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] rk,
                                             input logic mix);
    logic [7:0]   sb [0:15];
    logic [7:0]   sr [0:15];
    logic [7:0]   mc [0:15];
    logic [127:0] o;
    for (int k = 0; k < 16; k++) sb[k] = sbox(s[127 - 8 * k -: 8]);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        sr[4 * c + r] = sb[4 * ((c + r) % 4) + r];
    for (int c = 0; c < 4; c++) begin
      if (mix) begin
        mc[4*c]   = xtime(sr[4*c]) ^ gmul(sr[4*c+1], 8'h03) ^ sr[4*c+2] ^ sr[4*c+3];
        mc[4*c+1] = sr[4*c] ^ xtime(sr[4*c+1]) ^ gmul(sr[4*c+2], 8'h03) ^ sr[4*c+3];
        mc[4*c+2] = sr[4*c] ^ sr[4*c+1] ^ xtime(sr[4*c+2]) ^ gmul(sr[4*c+3], 8'h03);
        mc[4*c+3] = gmul(sr[4*c], 8'h03) ^ sr[4*c+1] ^ sr[4*c+2] ^ xtime(sr[4*c+3]);
      end else begin
        for (int r = 0; r < 4; r++) mc[4 * c + r] = sr[4 * c + r];
      end
    end
    for (int k = 0; k < 16; k++) o[127 - 8 * k -: 8] = mc[k];
    return o ^ rk;
  endfunction

  function automatic logic [127:0] aes_enc(input logic [255:0] k, input logic [127:0] pt);
    logic [127:0] s;
    s = pt ^ round_key(k, 0);
    for (int r = 1; r < 14; r++) s = aes_round(s, round_key(k, r), 1'b1);
    return aes_round(s, round_key(k, 14), 1'b0);
  endfunction

  // External round datapath and key expansion driven by the DUT.
  always_comb begin
    rk_i        = round_key(key_o, int'(rk_idx_o));
    rnd_state_i = aes_round(rnd_state_o, rk_i, rnd_mix_en_o);
  end

  // ---------------- helpers ------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Present one block, wait (bounded) for the result, check it and complete
  // the output handshake. 'k' is the key the DUT should be using; when kv=0
  // a different key is shown on cipher_key to prove it is not sampled.
  task automatic run_block(input string nm, input logic [255:0] k, input logic [127:0] pt,
                           input logic kv, input logic [127:0] exp);
    int lat;
    plain_text    = pt;
    cipher_key    = kv ? k : ~k;
    key_valid_in  = kv;
    data_valid_in = 1'b1;
    data_ready_in = 1'b1;
    #1;
    chk({nm, " ready"}, 256'(data_ready_out), 256'(1));
    tick();
    data_valid_in = 1'b0;
    key_valid_in  = 1'b0;
    cipher_key    = ~k;
    plain_text    = ~pt;
    lat = 0;
    while (!data_valid_out && lat < 40) begin
      tick();
      lat++;
    end
    chk({nm, " latency"}, 256'(lat), 256'(15));
    chk({nm, " ct"}, 256'(cipher_text), 256'(exp));
    chk({nm, " key_o"}, key_o, k);
    tick();
    chk({nm, " idle after handshake"}, 256'(data_valid_out), 256'(0));
  endtask

  typedef struct {
    logic [255:0] key;
    logic [127:0] pt;
    logic         kv;
    logic [127:0] ct;
  } vec_t;

  vec_t vecs [4];

  initial begin
    bit seen_rdy;
    bit seen_vld;
    total = 0;
    bad   = 0;
    clk   = 1'b0;
    reset = 1'b1;
    data_valid_in = 1'b1;
    plain_text    = PT_FIPS;
    key_valid_in  = 1'b0;
    cipher_key    = K_FIPS;
    data_ready_in = 1'b1;
`ifdef AES_SCHED_ABORT_EN
    abort = 1'b0;
`endif

    vecs[0] = '{key: 256'h0,  pt: 128'h0,   kv: 1'b1, ct: CT_ZERO};
    vecs[1] = '{key: K_FIPS,  pt: PT_FIPS,  kv: 1'b1, ct: CT_FIPS};
    vecs[2] = '{key: K_FIPS,  pt: PT_FIPS,  kv: 1'b0, ct: CT_FIPS};
    vecs[3] = '{key: K_FIPS,  pt: PT_ALT,   kv: 1'b0, ct: aes_enc(K_FIPS, PT_ALT)};

    // Reset state
    tick();
    tick();
    chk("rst ready",    256'(data_ready_out), 256'(0));
    chk("rst valid",    256'(data_valid_out), 256'(0));
    chk("rst ct",       256'(cipher_text),    256'(0));
    chk("rst rnd_st",   256'(rnd_state_o),    256'(0));
    chk("rst key_o",    key_o,                256'(0));
    chk("rst rk_idx",   256'(rk_idx_o),       256'(0));
    chk("rst mix_en",   256'(rnd_mix_en_o),   256'(1));

    // No key since reset: data_valid_in must not be acknowledged
    reset = 1'b0;
    seen_rdy = 1'b0;
    seen_vld = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (data_ready_out) seen_rdy = 1'b1;
      if (data_valid_out) seen_vld = 1'b1;
      tick();
    end
    chk("nokey ready never", 256'(seen_rdy), 256'(0));
    chk("nokey valid never", 256'(seen_vld), 256'(0));

    // Table-driven blocks, back to back
    for (int i = 0; i < 4; i++)
      run_block($sformatf("vec%0d", i), vecs[i].key, vecs[i].pt, vecs[i].kv, vecs[i].ct);

    // Backpressure: hold DONE for 10 cycles
    plain_text    = PT_FIPS;
    cipher_key    = ~K_FIPS;
    key_valid_in  = 1'b0;
    data_valid_in = 1'b1;
    data_ready_in = 1'b0;
    tick();
    data_valid_in = 1'b0;
    for (int i = 0; i < 40 && !data_valid_out; i++) tick();
    chk("bp valid rises", 256'(data_valid_out), 256'(1));
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("bp valid hold %0d", i), 256'(data_valid_out), 256'(1));
      chk($sformatf("bp ct hold %0d", i), 256'(cipher_text), 256'(CT_FIPS));
    end
    data_ready_in = 1'b1;
    tick();
    chk("bp valid drop", 256'(data_valid_out), 256'(0));
    chk("bp idle ready", 256'(data_ready_out), 256'(1));

    // Different key offered during ROUND is ignored; final-round controls
    plain_text    = PT_FIPS;
    cipher_key    = K_FIPS;
    key_valid_in  = 1'b1;
    data_valid_in = 1'b1;
    tick();
    key_valid_in  = 1'b0;
    data_valid_in = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      tick();
      if (i == 3) begin
        cipher_key    = 256'h0;
        key_valid_in  = 1'b1;
        data_valid_in = 1'b1;
        plain_text    = 128'h0;
      end
      if (i == 5) chk("busy ready low", 256'(data_ready_out), 256'(0));
      if (i == 12) begin
        key_valid_in  = 1'b0;
        data_valid_in = 1'b0;
      end
      if (i == 13) begin
        chk("round13 rk_idx", 256'(rk_idx_o), 256'(13));
        chk("round13 mix", 256'(rnd_mix_en_o), 256'(1));
      end
      if (i == 14) begin
        chk("final rk_idx", 256'(rk_idx_o), 256'(14));
        chk("final mix", 256'(rnd_mix_en_o), 256'(0));
        chk("final valid", 256'(data_valid_out), 256'(0));
      end
    end
    chk("keyign valid", 256'(data_valid_out), 256'(1));
    chk("keyign ct", 256'(cipher_text), 256'(CT_FIPS));
    chk("keyign key_o", key_o, K_FIPS);
    tick();

    // Reset pulsed at round 7
    plain_text    = PT_FIPS;
    cipher_key    = ~K_FIPS;
    data_valid_in = 1'b1;
    tick();
    data_valid_in = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    chk("r7 rk_idx", 256'(rk_idx_o), 256'(7));
    reset = 1'b1;
    tick();
    chk("r7 valid", 256'(data_valid_out), 256'(0));
    chk("r7 ready", 256'(data_ready_out), 256'(0));
    chk("r7 ct", 256'(cipher_text), 256'(0));
    chk("r7 rnd_st", 256'(rnd_state_o), 256'(0));
    chk("r7 key_o", key_o, 256'(0));
    chk("r7 rk_idx0", 256'(rk_idx_o), 256'(0));
    reset = 1'b0;
    data_valid_in = 1'b1;
    seen_rdy = 1'b0;
    seen_vld = 1'b0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (data_ready_out) seen_rdy = 1'b1;
      if (data_valid_out) seen_vld = 1'b1;
    end
    chk("r7 ready stays low", 256'(seen_rdy), 256'(0));
    chk("r7 no output", 256'(seen_vld), 256'(0));
    run_block("reload", K_FIPS, PT_FIPS, 1'b1, CT_FIPS);

`ifdef AES_SCHED_ABORT_EN
    // Abort at round 5
    plain_text    = PT_FIPS;
    data_valid_in = 1'b1;
    tick();
    data_valid_in = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("ab rk_idx", 256'(rk_idx_o), 256'(5));
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("ab valid", 256'(data_valid_out), 256'(0));
    chk("ab idle ready", 256'(data_ready_out), 256'(1));
    seen_vld = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (data_valid_out) seen_vld = 1'b1;
    end
    chk("ab no output", 256'(seen_vld), 256'(0));
    run_block("ab next", K_FIPS, PT_FIPS, 1'b0, CT_FIPS);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aes_round_sched.md
# aes_round_sched

Iterative round scheduler for the AES-256 encryption core. It accepts a plaintext/key pair through a valid/ready handshake and holds the 128-bit cipher state. It then steps an external single-round datapath and key-expansion unit through rounds 0..NUMS_OF_ROUND, and returns the ciphertext with backpressure. It sits between the TOP-level I/O and the shared round logic, so one round unit serves all rounds.

## Interface
- KEY_LEN, 256, cipher key width
- DATA_LEN, 128, block width
- NUMS_OF_ROUND, 14, rounds Nr; RK_W = $clog2(NUMS_OF_ROUND+1)
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- data_valid_in  in  1  plaintext valid
- data_ready_out  out  1  plaintext accepted when high with data_valid_in
- plain_text  in  DATA_LEN  plaintext block
- key_valid_in  in  1  cipher_key valid; sampled only in IDLE
- cipher_key  in  KEY_LEN  cipher key
- data_valid_out  out  1  ciphertext valid
- data_ready_in  in  1  downstream ready
- cipher_text  out  DATA_LEN  ciphertext; equals state register
- key_o  out  KEY_LEN  latched key to key expansion
- rk_idx_o  out  RK_W  requested round-key index
- rk_i  in  DATA_LEN  round key for rk_idx_o (combinational return)
- rnd_state_o  out  DATA_LEN  state to round datapath
- rnd_mix_en_o  out  1  MixColumns enable; 0 in final round
- rnd_state_i  in  DATA_LEN  round result (SubBytes, ShiftRows, optional MixColumns, AddRoundKey with rk_i)

## Operation
- States: IDLE, INIT, ROUND, FINAL, DONE.
- Key latch:
  - In IDLE, key_valid_in=1 loads cipher_key into key_o and sets key_loaded.
  - key_valid_in is ignored in all other states.
- data_ready_out = !reset && state==IDLE && (key_loaded || key_valid_in).
- On an accepted handshake, plain_text is loaded into the state register, round counter = 0, and the FSM goes IDLE→INIT. A key presented in the same cycle is the key used.
- INIT:
  - rk_idx_o=0; state <= state ^ rk_i; counter <= 1.
  - Next state is ROUND, or FINAL if NUMS_OF_ROUND==1.
- ROUND:
  - rk_idx_o=counter, rnd_mix_en_o=1, state <= rnd_state_i, counter++.
  - When counter == NUMS_OF_ROUND-1, the next state is FINAL.
- FINAL:
  - rk_idx_o=NUMS_OF_ROUND, rnd_mix_en_o=0, state <= rnd_state_i.
  - Next state is DONE.
- DONE:
  - data_valid_out=1 and cipher_text is held stable.
  - data_valid_out && data_ready_in → IDLE. key_loaded is kept, so the next block reuses the key.
- rnd_state_o always equals the state register.
- rnd_mix_en_o=1 in every state except FINAL.
- rk_idx_o = counter in every state except FINAL.

## Timing
- Handshake accepted at edge T → data_valid_out rises after edge T+NUMS_OF_ROUND+1 (15 cycles at default).
- Minimum spacing between accepted blocks: NUMS_OF_ROUND+3 cycles (DONE handshake, then one IDLE cycle).
- Backpressure: DONE is held for any number of cycles; cipher_text must not change while data_valid_out=1.
- Reset state while reset is high and on the cycle after it:
  - State IDLE, key_loaded=0, counter=0.
  - State register=0, key_o=0, cipher_text=0, rnd_state_o=0, rk_idx_o=0.
  - data_valid_out=0, data_ready_out=0, rnd_mix_en_o=1.
- Reset asserted mid-operation abandons the block with no output, and the key must be reloaded.
- data_valid_in outside IDLE is not acknowledged; the upstream must hold its request.

## Configuration
- AES_SCHED_ABORT_EN defined:
  - Adds input port abort (1 bit).
  - abort=1 in INIT, ROUND, FINAL or DONE forces IDLE at the next edge and drops data_valid_out. key_loaded is kept.
  - abort=1 in IDLE has no effect; abort takes priority over the DONE handshake.
- AES_SCHED_ABORT_EN undefined: the port is absent and the logic is not generated.

## Structure
- aes_pkg holds:
  - FSM state enum (IDLE=0, INIT, ROUND, FINAL, DONE);
  - default localparams AES_NR_256=14, AES_BLOCK=128, AES_KEY_256=256;
  - the RK_W function.
- Sub-module aes_round_cnt: loadable up-counter with terminal flags cnt_last_mid (==NR-1) and cnt_zero; instantiated once.
- Key expansion and the round function stay outside this block.

## Test plan
- FIPS-197 C.3, with the bench supplying reference key expansion and round model: key 000102…1e1f, pt 00112233445566778899aabbccddeeff → ct 8ea2b7ca516745bfeafc49904b496089, data_valid_out 15 cycles after acceptance.
- data_ready_in held 0 for 10 cycles in DONE → data_valid_out and cipher_text stable throughout; IDLE the cycle after ready rises.
- Second block with key_valid_in=0 after the first → accepted using the latched key, same ciphertext as a fresh load; data_valid_in with no key since reset → data_ready_out stays 0.
- reset pulsed at round 7 → all outputs 0 next cycle, no data_valid_out, data_ready_out=0 until key_valid_in.
- key_valid_in with a different key during ROUND → ignored; ciphertext matches the original key.
- With AES_SCHED_ABORT_EN: abort at round 5 → IDLE next edge, no output, next block accepted without reloading the key.
